fifo_serial_tx: RTL
===================

# fifo_serial_tx

Downstream drain stage for the team's show-ahead FIFO. Pops one word at a time through the FIFO's `ren`/`empty`/`rdata` interface and serializes it onto a single asynchronous-serial line: start bit, LSB-first data, optional even parity, stop bit. Sits between the FIFO and the chip pad, and runs back-to-back frames with no idle gap while the FIFO has data.

## Interface
- `data_bw`, 4: word width; must match the FIFO `data_bw`.
- `clks_per_bit`, 16: clock cycles per serial bit, ≥2.
- `parity_en`, 0: 1 inserts an even-parity bit after the data bits.
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: asynchronous, active-low (asserted at 0); deassertion synchronous to `clk` is the integrator's responsibility.
- `en`  in  1: permits starting new frames.
- `empty`  in  1: from FIFO; `rdata` is valid whenever 0.
- `rdata`  in  `data_bw`: FIFO head word (show-ahead).
- `ren`  out  1: pop strobe to FIFO, combinational, one cycle per word.
- `tx`  out  1: serial line, registered, idles high.
- `busy`  out  1: registered, 1 from the cycle after the pop through the last stop-bit cycle.
- `frames`  out  16: registered count of completed frames, wraps 0xFFFF→0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when `parity_en`=0.
- Pop condition: `ren` = `en` & !`empty` & (state==IDLE | (state==STOP & last baud cycle)). `ren` is never asserted while `reset` is asserted.
- On the pop edge:
  - capture `rdata` into the shift register;
  - compute parity = XOR of the word;
  - go to START, load `tx`=0, clear the baud and bit counters.
- START: hold `tx`=0 for `clks_per_bit` cycles, then go to DATA and drive bit 0.
- DATA: each bit is held `clks_per_bit` cycles, LSB first. After bit `data_bw`-1, go to PARITY (`tx`=parity) or to STOP (`tx`=1).
- STOP: hold `tx`=1 for `clks_per_bit` cycles. On its last cycle:
  - `frames` increments;
  - if the pop condition holds, start the next frame directly (START);
  - otherwise go to IDLE.
- `en` dropping mid-frame has no effect on the current frame; it only blocks the next pop.
- Baud counter width: $clog2(`clks_per_bit`). Bit counter width: $clog2(`data_bw`)+1. Both reset to 0 at every state entry.
- Reset (any time, including mid-frame):
  - immediately `tx`=1, `busy`=0, `frames`=0, state IDLE;
  - any word already popped is discarded and not re-fetched.

## Timing
- Pop edge = edge E. `tx` falls at E; the start bit spans cycles E..E+`clks_per_bit`-1.
- Frame length: (2 + `data_bw` + `parity_en`) × `clks_per_bit` cycles. Defaults give 96.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle. Zero idle cycles.
- From IDLE, first data word: `ren` is high in the same cycle `empty` falls (given `en`=1). `tx` falls on the next edge.
- `busy` rises at E and falls after the last stop-bit cycle, unless a new pop occurs there, in which case it stays 1.
- `frames` updates on the edge ending the stop bit.

## Structure
- Package `fifo_serial_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - constant `TX_IDLE_LEVEL`=1'b1.
- Sub-module `baud_tick_gen`: counter with `clks_per_bit` parameter, `clr` input and `tick` output (high on the last cycle of each bit).
- The FSM, shift register, parity and frame counter live in the top.

## Test plan
- Reset defaults: hold `reset`=0 with `empty`=0 → `tx`=1, `busy`=0, `ren`=0, `frames`=0.
- Single frame, `clks_per_bit`=4, `parity_en`=0, word 4'hA:
  - `ren` pulses once;
  - `tx` = 0,0,1,0,1,1 per 4-cycle bit (start, LSB-first data, stop), 24 cycles;
  - `frames`=1.
- Parity, `parity_en`=1, word 4'h7:
  - parity bit = 1;
  - frame is 28 cycles at `clks_per_bit`=4.
- Back-to-back: preload FIFO with 3'h words 1,2,3 → exactly 3 `ren` pulses, 72 contiguous cycles, no high gap between a stop bit and the next start bit, `frames`=3.
- `en` deasserted mid-frame 1 with the FIFO non-empty → frame 1 completes, no further `ren`, `tx` stays 1; reasserting `en` pops the next word the same cycle.
- Reset mid-DATA → `tx`=1 immediately (asynchronous), `frames`=0; after release, the next FIFO word transmits normally and the interrupted word is not resent.

Source files
------------

// File: rtl/fifo_serial_pkg.sv
// Shared types and constants for the FIFO-draining serial transmitter.
package fifo_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_serial_tx_baud_tick_gen.sv
// Bit-period counter: tick marks the last clock of each serial bit.
module baud_tick_gen #(
  parameter int clks_per_bit = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a show-ahead FIFO and sends them as start/LSB-first data/[even parity]/stop frames.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int data_bw      = 4,
  parameter int clks_per_bit = 16,
  parameter bit parity_en    = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               empty,
  input  logic [data_bw-1:0] rdata,
  output logic               ren,
  output logic               tx,
  output logic               busy,
  output logic [15:0]        frames
);

  localparam int BCW = $clog2(data_bw) + 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(data_bw - 1);

  tx_state_t          state;
  logic [data_bw-1:0] shreg;
  logic               par;
  logic [BCW-1:0]     bit_cnt;
  logic               tick;
  logic               last_stop;
  logic               baud_clr;

  assign last_stop = (state == STOP) && tick;
  // Gated by reset so a word is never popped while the frame logic is held clear.
  assign ren       = reset && en && !empty && ((state == IDLE) || last_stop);
  assign baud_clr  = (state == IDLE) || ren;

  baud_tick_gen #(
    .clks_per_bit(clks_per_bit)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (baud_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= TX_IDLE_LEVEL;
      busy    <= 1'b0;
      frames  <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (last_stop) frames <= frames + 16'd1;

      if (ren) begin
        shreg   <= rdata;
        par     <= ^rdata;
        bit_cnt <= '0;
        tx      <= 1'b0;
        busy    <= 1'b1;
        state   <= START;
      end else begin
        case (state)
          IDLE: begin
            tx   <= TX_IDLE_LEVEL;
            busy <= 1'b0;
          end
          START: if (tick) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (parity_en) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= TX_IDLE_LEVEL;
                state <= STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: if (tick) begin
            tx      <= TX_IDLE_LEVEL;
            bit_cnt <= '0;
            state   <= STOP;
          end
          STOP: if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
